// File: rtl/vend_pkg.sv
// Shared types and default sizing for the vending intake path.
package vend_pkg;

   localparam int unsigned NICKEL_DEPTH_DEF  = 10;
   localparam int unsigned DIME_DEPTH_DEF    = 5;
   localparam int unsigned QUARTER_DEPTH_DEF = 3;
   localparam int unsigned DOLLAR_DEPTH_DEF  = 1;
   localparam int unsigned SALE_CNT_W_DEF    = 16;

   typedef enum logic [1:0] {
      NICKEL  = 2'd0,
      DIME    = 2'd1,
      QUARTER = 2'd2,
      DOLLAR  = 2'd3
   } coin_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SALE   = 2'd1,
      REFUND = 2'd2
   } stacker_state_t;

   // One ejected coin event: valid strobe plus denomination.
   typedef struct packed {
      logic  valid;
      coin_t kind;
   } coin_evt_t;

endpackage

// File: rtl/coin_stacker_if.sv
// Coin intake / stack / eject bus between the stacker and its neighbours.
interface coin_stacker_if #(
   parameter int unsigned NICKEL_DEPTH  = vend_pkg::NICKEL_DEPTH_DEF,
   parameter int unsigned DIME_DEPTH    = vend_pkg::DIME_DEPTH_DEF,
   parameter int unsigned QUARTER_DEPTH = vend_pkg::QUARTER_DEPTH_DEF,
   parameter int unsigned DOLLAR_DEPTH  = vend_pkg::DOLLAR_DEPTH_DEF,
   parameter int unsigned SALE_CNT_W    = vend_pkg::SALE_CNT_W_DEF
);
   import vend_pkg::*;

   logic                     coin_valid;
   coin_t                    coin_type;
   logic                     refund_req;
   logic                     vend;
   logic [NICKEL_DEPTH-1:0]  nickels;
   logic [DIME_DEPTH-1:0]    dimes;
   logic [QUARTER_DEPTH-1:0] quarters;
   logic [DOLLAR_DEPTH-1:0]  dollars;
   logic                     refunding;
   logic                     coin_reject;
   logic                     eject_valid;
   coin_t                    eject_type;
   logic                     sale_pulse;
   logic [SALE_CNT_W-1:0]    sale_count;

   modport master (
      output coin_valid, coin_type, refund_req, vend,
      input  nickels, dimes, quarters, dollars, refunding, coin_reject,
             eject_valid, eject_type, sale_pulse, sale_count
   );

   modport slave (
      input  coin_valid, coin_type, refund_req, vend,
      output nickels, dimes, quarters, dollars, refunding, coin_reject,
             eject_valid, eject_type, sale_pulse, sale_count
   );

endinterface

// File: rtl/thermo_stack.sv
// Thermometer-coded coin stack; bit 0 fills first. Priority clr > pop > push.
module thermo_stack #(
   parameter int unsigned DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic             clr,
   output logic [DEPTH-1:0] q,
   output logic             full,
   output logic             empty
);

   // Shift-in of a one keeps the code contiguous for any DEPTH, including 1.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (pop) begin
         q <= q >> 1;
      end else if (push) begin
         q <= (q << 1) | DEPTH'(1);
      end
   end

   assign full  = q[DEPTH-1];
   assign empty = ~q[0];

endmodule

// File: rtl/coin_stacker.sv
// Coin intake stage: stacks accepted coins, commits sales on vend, ejects on refund.
module coin_stacker
   import vend_pkg::*;
#(
   parameter int unsigned NICKEL_DEPTH  = NICKEL_DEPTH_DEF,
   parameter int unsigned DIME_DEPTH    = DIME_DEPTH_DEF,
   parameter int unsigned QUARTER_DEPTH = QUARTER_DEPTH_DEF,
   parameter int unsigned DOLLAR_DEPTH  = DOLLAR_DEPTH_DEF,
   parameter int unsigned SALE_CNT_W    = SALE_CNT_W_DEF
) (
   input  logic          clock,
   input  logic          reset_n,
   coin_stacker_if.slave bus
);

   localparam int unsigned NUM_COINS = 4;

   stacker_state_t          state_q, state_nxt;
   logic [NUM_COINS-1:0]    push, pop, full, empty;
   logic                    clr;
   logic                    last;

   logic [NICKEL_DEPTH-1:0]  nickel_q;
   logic [DIME_DEPTH-1:0]    dime_q;
   logic [QUARTER_DEPTH-1:0] quarter_q;
   logic [DOLLAR_DEPTH-1:0]  dollar_q;

   logic                  refunding_q, refunding_nxt;
   logic                  coin_reject_q, coin_reject_nxt;
   coin_evt_t             eject_q, eject_nxt;
   logic                  sale_pulse_q, sale_pulse_nxt;
   logic [SALE_CNT_W-1:0] sale_count_q, sale_count_nxt;

   thermo_stack #(.DEPTH(NICKEL_DEPTH)) u_nickel (
      .clock  (clock),
      .reset_n(reset_n),
      .push   (push[NICKEL]),
      .pop    (pop[NICKEL]),
      .clr    (clr),
      .q      (nickel_q),
      .full   (full[NICKEL]),
      .empty  (empty[NICKEL])
   );

   thermo_stack #(.DEPTH(DIME_DEPTH)) u_dime (
      .clock  (clock),
      .reset_n(reset_n),
      .push   (push[DIME]),
      .pop    (pop[DIME]),
      .clr    (clr),
      .q      (dime_q),
      .full   (full[DIME]),
      .empty  (empty[DIME])
   );

   thermo_stack #(.DEPTH(QUARTER_DEPTH)) u_quarter (
      .clock  (clock),
      .reset_n(reset_n),
      .push   (push[QUARTER]),
      .pop    (pop[QUARTER]),
      .clr    (clr),
      .q      (quarter_q),
      .full   (full[QUARTER]),
      .empty  (empty[QUARTER])
   );

   thermo_stack #(.DEPTH(DOLLAR_DEPTH)) u_dollar (
      .clock  (clock),
      .reset_n(reset_n),
      .push   (push[DOLLAR]),
      .pop    (pop[DOLLAR]),
      .clr    (clr),
      .q      (dollar_q),
      .full   (full[DOLLAR]),
      .empty  (empty[DOLLAR])
   );

   // Next-state, stack controls and next values of the registered outputs.
   always_comb begin
      state_nxt       = state_q;
      push            = '0;
      pop             = '0;
      clr             = 1'b0;
      last            = 1'b0;
      coin_reject_nxt = 1'b0;
      eject_nxt       = '0;
      sale_pulse_nxt  = 1'b0;
      sale_count_nxt  = sale_count_q;

      unique case (state_q)
         IDLE: begin
            if (bus.vend) begin
               state_nxt       = SALE;
               coin_reject_nxt = bus.coin_valid;
            end else if (bus.refund_req && !(&empty)) begin
               state_nxt       = REFUND;
               coin_reject_nxt = bus.coin_valid;
            end else if (bus.coin_valid) begin
               if (full[bus.coin_type]) begin
                  coin_reject_nxt = 1'b1;
               end else begin
                  push[bus.coin_type] = 1'b1;
               end
            end
         end

         SALE: begin
            clr             = 1'b1;
            sale_pulse_nxt  = 1'b1;
            sale_count_nxt  = sale_count_q + SALE_CNT_W'(1);
            coin_reject_nxt = bus.coin_valid;
            state_nxt       = IDLE;
         end

         REFUND: begin
            coin_reject_nxt = bus.coin_valid;
            // Highest denomination first; leave once the popped coin was the final one.
            if (!empty[DOLLAR]) begin
               pop[DOLLAR]     = 1'b1;
               eject_nxt.valid = 1'b1;
               eject_nxt.kind  = DOLLAR;
               last = ((dollar_q >> 1) == '0) && empty[QUARTER] && empty[DIME] && empty[NICKEL];
            end else if (!empty[QUARTER]) begin
               pop[QUARTER]    = 1'b1;
               eject_nxt.valid = 1'b1;
               eject_nxt.kind  = QUARTER;
               last = ((quarter_q >> 1) == '0) && empty[DIME] && empty[NICKEL];
            end else if (!empty[DIME]) begin
               pop[DIME]       = 1'b1;
               eject_nxt.valid = 1'b1;
               eject_nxt.kind  = DIME;
               last = ((dime_q >> 1) == '0) && empty[NICKEL];
            end else if (!empty[NICKEL]) begin
               pop[NICKEL]     = 1'b1;
               eject_nxt.valid = 1'b1;
               eject_nxt.kind  = NICKEL;
               last = ((nickel_q >> 1) == '0);
            end else begin
               last = 1'b1;
            end
            if (last) begin
               state_nxt = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase

      refunding_nxt = (state_nxt == REFUND);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         refunding_q   <= 1'b0;
         coin_reject_q <= 1'b0;
         eject_q       <= '0;
         sale_pulse_q  <= 1'b0;
         sale_count_q  <= '0;
      end else begin
         state_q       <= state_nxt;
         refunding_q   <= refunding_nxt;
         coin_reject_q <= coin_reject_nxt;
         eject_q       <= eject_nxt;
         sale_pulse_q  <= sale_pulse_nxt;
         sale_count_q  <= sale_count_nxt;
      end
   end

   assign bus.nickels     = nickel_q;
   assign bus.dimes       = dime_q;
   assign bus.quarters    = quarter_q;
   assign bus.dollars     = dollar_q;
   assign bus.refunding   = refunding_q;
   assign bus.coin_reject = coin_reject_q;
   assign bus.eject_valid = eject_q.valid;
   assign bus.eject_type  = eject_q.kind;
   assign bus.sale_pulse  = sale_pulse_q;
   assign bus.sale_count  = sale_count_q;

endmodule
